// File: rtl/seven_segment_to_priority_decoder_if.sv
// Segment-pattern input and decoded-digit outputs of seven_segment_to_priority_decoder.
// The master side drives seg; the slave side (the decoder) drives the result signals.
interface seven_segment_to_priority_decoder_if;
    logic [6:0] seg;
    logic [7:0] data_out;
    logic       no_data_out;
    logic       valid;
    logic       err;

    modport master (output seg, input data_out, no_data_out, valid, err);
    modport slave  (input seg, output data_out, no_data_out, valid, err);
endinterface

// File: rtl/seven_segment_to_priority_decoder.sv
// Debounces a 7-segment pattern and decodes digits 0..7 to a one-hot index.
// Define SEG_ACTIVE_LOW_EN for common-anode (inverted) segment inputs.
module seven_segment_to_priority_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    seven_segment_to_priority_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    localparam logic [3:0] CNT_ACCEPT = 4'(STABLE_CYCLES - 1);

    state_t     state;
    logic [6:0] seg_in;
    logic [6:0] s;
    logic [3:0] cnt;
    logic [4:0] dec;
    logic       seg_eq;
    logic       accept;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    // Result is {legal, blank, digit index}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   return 5'b10_000;
            7'h06:   return 5'b10_001;
            7'h5B:   return 5'b10_010;
            7'h4F:   return 5'b10_011;
            7'h66:   return 5'b10_100;
            7'h6D:   return 5'b10_101;
            7'h7D:   return 5'b10_110;
            7'h07:   return 5'b10_111;
            7'h00:   return 5'b11_000;
            default: return 5'b00_000;
        endcase
    endfunction

    always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
        seg_in = ~bus.seg;
`else
        seg_in = bus.seg;
`endif
        seg_eq = (seg_in == s);
        accept = (state == COUNT) && seg_eq && (cnt == CNT_ACCEPT);
        dec    = decode(seg_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            s               <= 7'h00;
            cnt             <= 4'd0;
            bus.data_out    <= 8'h00;
            bus.no_data_out <= 1'b1;
            bus.valid       <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            s         <= seg_in;
            cnt       <= seg_eq ? sat_inc(cnt) : 4'd0;
            bus.valid <= 1'b0;
            case (state)
                IDLE: state <= COUNT;
                COUNT: begin
                    if (accept) begin
                        state <= HOLD;
                        // Illegal patterns only flag the error; the last good digit stays visible.
                        if (!dec[4]) begin
                            bus.err <= 1'b1;
                        end else begin
                            bus.err         <= 1'b0;
                            bus.valid       <= 1'b1;
                            bus.no_data_out <= dec[3];
                            bus.data_out    <= dec[3] ? 8'h00 : (8'b1 << dec[2:0]);
                        end
                    end
                end
                HOLD: begin
                    if (!seg_eq) state <= COUNT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seven_segment_to_priority_decoder.sv
// Directed bench: each step pushes expected outputs for future edges; a negedge monitor pops and checks them.
module tb_seven_segment_to_priority_decoder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        int          cyc;
        logic [10:0] v;
        string       tag;
    } exp_t;
    exp_t q[$];

    seven_segment_to_priority_decoder_if bus ();

    seven_segment_to_priority_decoder #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [6:0] phys(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_at(input int off, input logic [7:0] d, input logic n,
                          input logic v, input logic e, input string tag);
        exp_t x;
        x.cyc = cyc + off;
        x.v   = {d, n, v, e};
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic exp_range(input int a, input int b, input logic [7:0] d, input logic n,
                             input logic v, input logic e, input string tag);
        for (int k = a; k <= b; k++) exp_at(k, d, n, v, e, tag);
    endtask

    // Output is {data_out, no_data_out, valid, err}.
    always @(negedge clk) begin
        exp_t        x;
        logic [10:0] obs;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x   = q.pop_front();
            obs = {bus.data_out, bus.no_data_out, bus.valid, bus.err};
            checks++;
            assert (x.cyc == cyc && obs === x.v) else begin
                errors++;
                $error("FAIL %s edge=%0d: observed %h required %h", x.tag, x.cyc, obs, x.v);
            end
        end
    end

    logic [6:0] pats [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    initial begin
        logic [7:0] prev;
        rst     = 1'b1;
        bus.seg = phys(7'h00);
        tick(2);
        exp_at(0, 8'h00, 1, 0, 0, "reset_state");

        // Steady 4: accepted at edge 5, then no further pulse
        rst = 1'b0;
        bus.seg = phys(7'h66);
        exp_range(1, 4, 8'h00, 1, 0, 0, "pre_4");
        exp_at(5, 8'h10, 0, 1, 0, "accept_4");
        exp_range(6, 25, 8'h10, 0, 0, 0, "hold_4");
        tick(25);

        // 7 for three cycles, then 1 steady
        bus.seg = phys(7'h07);
        exp_range(1, 3, 8'h10, 0, 0, 0, "short_7");
        tick(3);
        bus.seg = phys(7'h06);
        exp_range(1, 4, 8'h10, 0, 0, 0, "pre_1");
        exp_at(5, 8'h02, 0, 1, 0, "accept_1");
        exp_range(6, 8, 8'h02, 0, 0, 0, "hold_1");
        tick(8);

        // Illegal pattern sets sticky err, data held
        bus.seg = phys(7'h7F);
        exp_range(1, 4, 8'h02, 0, 0, 0, "pre_ill");
        exp_range(5, 8, 8'h02, 0, 0, 1, "illegal");
        tick(8);
        bus.seg = phys(7'h3F);
        exp_range(1, 4, 8'h02, 0, 0, 1, "err_sticky");
        exp_at(5, 8'h01, 0, 1, 0, "accept_0");
        exp_at(6, 8'h01, 0, 0, 0, "hold_0");
        tick(6);

        // Digit 5 then blank
        bus.seg = phys(7'h6D);
        exp_at(5, 8'h20, 0, 1, 0, "accept_5");
        tick(7);
        bus.seg = phys(7'h00);
        exp_range(1, 4, 8'h20, 0, 0, 0, "pre_blank");
        exp_at(5, 8'h00, 1, 1, 0, "accept_blank");
        exp_at(6, 8'h00, 1, 0, 0, "hold_blank");
        tick(6);

        // Glitch restarts counting and re-accepts the same value
        bus.seg = phys(7'h4F);
        exp_at(5, 8'h08, 0, 1, 0, "accept_3");
        tick(7);
        bus.seg = phys(7'h5B);
        exp_at(1, 8'h08, 0, 0, 0, "glitch");
        tick(1);
        bus.seg = phys(7'h4F);
        exp_range(1, 4, 8'h08, 0, 0, 0, "glitch_wait");
        exp_at(5, 8'h08, 0, 1, 0, "reaccept_3");
        exp_at(6, 8'h08, 0, 0, 0, "reaccept_end");
        tick(6);

        // Change on the acceptance edge cancels it
        bus.seg = phys(7'h66);
        tick(4);
        bus.seg = phys(7'h07);
        exp_range(1, 4, 8'h08, 0, 0, 0, "cancelled");
        exp_at(5, 8'h80, 0, 1, 0, "accept_7");
        tick(7);

        // Reset on cycle 3 of a stable 3
        bus.seg = phys(7'h4F);
        exp_range(1, 2, 8'h80, 0, 0, 0, "pre_rst");
        tick(2);
        rst = 1'b1;
        exp_at(1, 8'h00, 1, 0, 0, "mid_rst");
        tick(1);
        rst = 1'b0;
        exp_range(1, 4, 8'h00, 1, 0, 0, "post_rst");
        exp_at(5, 8'h08, 0, 1, 0, "accept_after_rst");
        exp_at(6, 8'h08, 0, 0, 0, "hold_after_rst");
        tick(6);

        // Every digit in turn
        prev = 8'h08;
        for (int d = 0; d < 8; d++) begin
            bus.seg = phys(pats[d]);
            exp_range(1, 4, prev, 0, 0, 0, "digit_wait");
            exp_at(5, 8'(1 << d), 0, 1, 0, "digit_accept");
            exp_at(6, 8'(1 << d), 0, 0, 0, "digit_hold");
            prev = 8'(1 << d);
            tick(6);
        end

        tick(2);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seven_segment_to_priority_decoder.md
SEVEN_SEGMENT_TO_PRIORITY_DECODER -- requirements
Module: seven_segment_to_priority_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive equal samples required before a pattern is accepted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port seg, input, 7 bits: segment pattern, bit0=a .. bit6=g, active-high unless REQ-021 applies.
REQ-005 The block SHALL have port data_out, output, 8 bits: one-hot reconstruction of the displayed digit index.
REQ-006 The block SHALL have port no_data_out, output, 1 bit: high when the accepted pattern is blank.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle pulse on each accepted legal pattern.
REQ-008 The block SHALL have port err, output, 1 bit: sticky flag, high when the last accepted pattern was illegal.

Function
REQ-009 Legal patterns SHALL decode as: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x00->blank; all other values are illegal.
REQ-010 A sample register s SHALL capture seg every cycle; a 4-bit counter cnt SHALL load 0 when seg!=s and increment, saturating at 15, when seg==s.
REQ-011 The FSM SHALL have states IDLE (reset only), COUNT (waiting for stability) and HOLD (accepted, waiting for change).
REQ-012 Transitions: IDLE->COUNT on the first cycle after reset; COUNT->HOLD on acceptance; HOLD->COUNT when seg!=s; all other cases hold state.
REQ-013 Acceptance SHALL occur in COUNT on the edge where seg==s and cnt==STABLE_CYCLES-1, so a pattern first present before edge 1 updates outputs at edge STABLE_CYCLES+1.
REQ-014 On acceptance of digit d: data_out SHALL be 1<<d, no_data_out 0, err 0, and valid high for exactly one cycle.
REQ-015 On acceptance of blank: data_out SHALL be 0x00, no_data_out 1, err 0, and valid high for one cycle.
REQ-016 On acceptance of an illegal pattern: err SHALL be 1, data_out and no_data_out SHALL hold, and valid SHALL stay 0.
REQ-017 Only one acceptance per stable period; a pattern held indefinitely in HOLD SHALL produce no further valid pulses.
REQ-018 A glitch (seg changes, then returns) SHALL restart counting, and re-acceptance of the same value SHALL pulse valid again.
REQ-019 A change of seg on the acceptance edge SHALL cancel acceptance: cnt loads 0 and outputs hold.

Reset
REQ-020 While rst is high at a clock edge: state IDLE, s=0x00, cnt=0, data_out=0x00, no_data_out=1, valid=0, err=0; reset mid-count or mid-pulse SHALL abort without acceptance.

Configuration
REQ-021 With macro SEG_ACTIVE_LOW_EN defined, seg SHALL be inverted before sampling (common-anode input, blank = 0x7F); without it, seg SHALL be used as-is and all behaviour is as in REQ-009..REQ-020.

Verification
REQ-022 STABLE_CYCLES=4, after reset drive seg=0x66 steady -> at edge 5: data_out=0x10, no_data_out=0, valid pulses for 1 cycle; no further pulse over 20 cycles.
REQ-023 Drive seg=0x07 for 3 cycles, then 0x06 steady -> no acceptance of 0x07; at edge 5 after the change: data_out=0x02, valid pulses.
REQ-024 Drive seg=0x7F steady (illegal) -> err=1 at edge 5, valid stays 0, data_out keeps its previous value; then 0x3F steady -> data_out=0x01, err=0, valid pulses.
REQ-025 Drive seg=0x00 steady after digit 5 was accepted -> data_out=0x00, no_data_out=1, valid pulses.
REQ-026 Assert rst on cycle 3 of a stable 0x4F -> all outputs return to reset values; after release, acceptance occurs STABLE_CYCLES+1 edges later with data_out=0x08.
REQ-027 Build with SEG_ACTIVE_LOW_EN and drive seg=0x40 (inverse of 0x3F) -> data_out=0x01 after STABLE_CYCLES+1 edges.
